// File: rtl/sync_fifo_lvl_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_lvl_if
// Brief    : Write/read handshake and status bundle for sync_fifo_lvl.
// Revision : 1.0 - initial release
// ============================================================================
interface sync_fifo_lvl_if #(
  parameter int P_NBIT_D = 16,
  parameter int P_NBIT_A = 4
);
  logic                i_wr;
  logic [P_NBIT_D-1:0] i_wdata;
  logic                i_rd;
  logic [P_NBIT_D-1:0] o_rdata;
  logic                o_full;
  logic                o_empty;
  logic                o_afull;
  logic                o_aempty;
  logic [P_NBIT_A:0]   o_level;
  logic                o_ovf;
  logic                o_udf;

  modport master (
    output i_wr, i_wdata, i_rd,
    input  o_rdata, o_full, o_empty, o_afull, o_aempty, o_level, o_ovf, o_udf
  );

  modport slave (
    input  i_wr, i_wdata, i_rd,
    output o_rdata, o_full, o_empty, o_afull, o_aempty, o_level, o_ovf, o_udf
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_lvl.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_lvl
// Brief    : Single-clock FIFO with fill level, almost flags, sticky error
//            flags, synchronous flush and registered-read or FWFT output.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_lvl #(
  parameter int P_NBIT_D = 16,
  parameter int P_NBIT_A = 4,
  parameter int P_FWFT   = 0,
  parameter int P_AFULL  = 12,
  parameter int P_AEMPTY = 3
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        i_clr,
  sync_fifo_lvl_if.slave   bus
);

  localparam int                c_DEPTH    = 2 ** P_NBIT_A;
  localparam logic [P_NBIT_A:0] c_LVL_FULL = (P_NBIT_A + 1)'(c_DEPTH);
  localparam logic [P_NBIT_A:0] c_LVL_AF   = (P_NBIT_A + 1)'(P_AFULL);
  localparam logic [P_NBIT_A:0] c_LVL_AE   = (P_NBIT_A + 1)'(P_AEMPTY);

  logic [P_NBIT_D-1:0] r_mem [c_DEPTH];
  logic [P_NBIT_A:0]   r_wptr;
  logic [P_NBIT_A:0]   r_rptr;
  logic                r_full;
  logic                r_empty;
  logic                r_afull;
  logic                r_aempty;
  logic                r_ovf;
  logic                r_udf;

  logic                w_acc_wr;
  logic                w_acc_rd;
  logic [P_NBIT_A:0]   w_wptr_next;
  logic [P_NBIT_A:0]   w_rptr_next;
  logic [P_NBIT_A:0]   w_level_next;
  logic [P_NBIT_A-1:0] w_waddr;
  logic [P_NBIT_A-1:0] w_raddr;

  // Level is the modular pointer distance; the wrap bit disambiguates full from empty.
  always_comb begin
    w_acc_wr     = bus.i_wr & ~r_full;
    w_acc_rd     = bus.i_rd & ~r_empty;
    w_wptr_next  = r_wptr + (P_NBIT_A + 1)'(w_acc_wr);
    w_rptr_next  = r_rptr + (P_NBIT_A + 1)'(w_acc_rd);
    w_level_next = w_wptr_next - w_rptr_next;
    w_waddr      = r_wptr[P_NBIT_A-1:0];
    w_raddr      = r_rptr[P_NBIT_A-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (i_clr) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_wptr   <= w_wptr_next;
      r_rptr   <= w_rptr_next;
      r_full   <= (w_level_next == c_LVL_FULL);
      r_empty  <= (w_level_next == '0);
      r_afull  <= (w_level_next >= c_LVL_AF);
      r_aempty <= (w_level_next <= c_LVL_AE);
      r_ovf    <= r_ovf | (bus.i_wr & r_full);
      r_udf    <= r_udf | (bus.i_rd & r_empty);
    end
  end

  // Storage is deliberately not reset or flushed.
  always_ff @(posedge clk) begin
    if (w_acc_wr && !i_clr) begin
      r_mem[w_waddr] <= bus.i_wdata;
    end
  end

  generate
    if (P_FWFT != 0) begin : g_fwft
      assign bus.o_rdata = r_mem[w_raddr];
    end else begin : g_reg_read
      logic [P_NBIT_D-1:0] r_rdata;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rdata <= '0;
        end else if (i_clr) begin
          r_rdata <= '0;
        end else if (w_acc_rd) begin
          r_rdata <= r_mem[w_raddr];
        end
      end

      assign bus.o_rdata = r_rdata;
    end
  endgenerate

  assign bus.o_full   = r_full;
  assign bus.o_empty  = r_empty;
  assign bus.o_afull  = r_afull;
  assign bus.o_aempty = r_aempty;
  assign bus.o_level  = r_wptr - r_rptr;
  assign bus.o_ovf    = r_ovf;
  assign bus.o_udf    = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_lvl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_lvl
// Brief    : Queue-model scoreboard bench driving a registered-read and an
//            FWFT instance of sync_fifo_lvl with identical stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_lvl;

  localparam int c_DEPTH = 16;
  localparam int c_AF    = 12;
  localparam int c_AE    = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr   = 1'b0;
  logic        wr    = 1'b0;
  logic        rd    = 1'b0;
  logic [15:0] wdata = '0;
  logic        mon_en = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] m_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] m_rdata = '0;
  logic        m_ovf   = 1'b0;
  logic        m_udf   = 1'b0;

  sync_fifo_lvl_if #(.P_NBIT_D(16), .P_NBIT_A(4)) if0 ();
  sync_fifo_lvl_if #(.P_NBIT_D(16), .P_NBIT_A(4)) if1 ();

  assign if0.i_wr    = wr;
  assign if0.i_rd    = rd;
  assign if0.i_wdata = wdata;
  assign if1.i_wr    = wr;
  assign if1.i_rd    = rd;
  assign if1.i_wdata = wdata;

  sync_fifo_lvl #(.P_NBIT_D(16), .P_NBIT_A(4), .P_FWFT(0), .P_AFULL(c_AF), .P_AEMPTY(c_AE))
    u_dut_reg (.clk(clk), .rst_n(rst_n), .i_clr(clr), .bus(if0));

  sync_fifo_lvl #(.P_NBIT_D(16), .P_NBIT_A(4), .P_FWFT(1), .P_AFULL(c_AF), .P_AEMPTY(c_AE))
    u_dut_fwft (.clk(clk), .rst_n(rst_n), .i_clr(clr), .bus(if1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue; every accepted pop is queued as an expected read.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      m_q.delete();
      exp_q.delete();
      m_rdata = '0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      int  sz;
      bit  acc_w;
      bit  acc_r;
      sz    = m_q.size();
      acc_w = wr && (sz < c_DEPTH);
      acc_r = rd && (sz > 0);
      if (wr && sz == c_DEPTH) m_ovf = 1'b1;
      if (rd && sz == 0)       m_udf = 1'b1;
      if (acc_r) begin
        m_rdata = m_q.pop_front();
        exp_q.push_back(m_rdata);
      end
      if (acc_w) m_q.push_back(wdata);
    end
  end

  // Monitor: compares both DUTs against the model away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      int sz;
      sz = m_q.size();
      chk("level_reg",   32'(if0.o_level),  sz);
      chk("level_fwft",  32'(if1.o_level),  sz);
      chk("full_reg",    32'(if0.o_full),   32'(sz == c_DEPTH));
      chk("full_fwft",   32'(if1.o_full),   32'(sz == c_DEPTH));
      chk("empty_reg",   32'(if0.o_empty),  32'(sz == 0));
      chk("empty_fwft",  32'(if1.o_empty),  32'(sz == 0));
      chk("afull_reg",   32'(if0.o_afull),  32'(sz >= c_AF));
      chk("afull_fwft",  32'(if1.o_afull),  32'(sz >= c_AF));
      chk("aempty_reg",  32'(if0.o_aempty), 32'(sz <= c_AE));
      chk("aempty_fwft", 32'(if1.o_aempty), 32'(sz <= c_AE));
      chk("ovf_reg",     32'(if0.o_ovf),    32'(m_ovf));
      chk("ovf_fwft",    32'(if1.o_ovf),    32'(m_ovf));
      chk("udf_reg",     32'(if0.o_udf),    32'(m_udf));
      chk("udf_fwft",    32'(if1.o_udf),    32'(m_udf));
      if (exp_q.size() > 0) chk("rdata_pop_reg", 32'(if0.o_rdata), 32'(exp_q.pop_front()));
      else                  chk("rdata_hold_reg", 32'(if0.o_rdata), 32'(m_rdata));
      if (sz > 0) chk("rdata_head_fwft", 32'(if1.o_rdata), 32'(m_q[0]));
    end
  end

  task automatic step(input logic w, input logic r, input logic [15:0] d, input logic c);
    @(negedge clk);
    wr    = w;
    rd    = r;
    wdata = d;
    clr   = c;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 16'(i), 1'b0);
    step(1'b1, 1'b0, 16'hDEAD, 1'b0);
    step(1'b1, 1'b0, 16'hDEAD, 1'b0);
    step(1'b1, 1'b1, 16'hDEAD, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1);

    step(1'b1, 1'b0, 16'h00AA, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 16'($urandom), 1'b0);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'($urandom), 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0100 + 16'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      int pw;
      pw = (i < 200) ? 70 : 30;
      step(1'($urandom_range(99) < pw), 1'($urandom_range(99) < 100 - pw),
           16'($urandom), 1'($urandom_range(63) == 0));
    end

    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 16'($urandom), 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0200 + 16'(i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo_lvl.md
# sync_fifo_lvl

Parametrised single-clock FIFO with a fill-level output, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a build-time choice between registered-read and first-word-fall-through (FWFT) output. It is the general-purpose buffer between the waveform sample producers and the DAC/streaming consumers in the same clock domain. Storage is an internally inferred register array with no vendor primitive, so depth is 2**p_nbit_a words.

## Interface
- p_nbit_d, 16, data width in bits
- p_nbit_a, 4, address width; depth = 2**p_nbit_a
- p_fwft, 0, 0 = registered read (data one cycle after rd); 1 = FWFT (head word visible while empty=0)
- p_afull, 12, afull asserts when level >= p_afull; legal range 1..depth
- p_aempty, 3, aempty asserts when level <= p_aempty; legal range 0..depth-1

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush
- wr  in  1  write request
- wdata  in  p_nbit_d  write data
- rd  in  1  read request (pop)
- rdata  out  p_nbit_d  read data
- full  out  1  level == depth
- empty  out  1  level == 0
- afull  out  1  almost full
- aempty  out  1  almost empty
- level  out  p_nbit_a+1  stored word count, 0..depth
- ovf  out  1  sticky: write attempted while full
- udf  out  1  sticky: read attempted while empty

## Operation
- Pointers wptr/rptr are p_nbit_a+1 bits. The MSB is the wrap bit and the low bits are the address. Both wrap modulo 2**(p_nbit_a+1).
- A write is accepted when wr & ~full. A read is accepted when rd & ~empty. Acceptance is judged on the current registered flags.
- Simultaneous wr & rd:
  - Not full and not empty: both are accepted and level is unchanged.
  - Full: the read is accepted, the write is rejected, and ovf is set.
  - Empty: the write is accepted, the read is rejected, and udf is set.
- level_next = level + acc_wr - acc_rd.
- full, empty, afull and aempty are registered from level_next. All of them are therefore consistent with level in every cycle.
- p_fwft=0: on an accepted read, rdata <= mem[rptr]. Otherwise rdata holds its value.
- p_fwft=1: rdata = mem[rptr], read combinationally. rdata is valid whenever empty=0 and is undefined-but-stable when empty=1. rd pops the displayed word.
- ovf and udf stay set until clr or reset.
- clr has priority over wr and rd in the same cycle:
  - Pointers, level, ovf and udf are zeroed.
  - full=0, empty=1, afull=0, aempty=1.
  - rdata is cleared to 0 when p_fwft=0.
  - Memory contents are not cleared.
- Asynchronous reset gives the same output values as clr. It takes effect immediately and may be asserted mid-transfer; any in-flight word is discarded.
- Out-of-range p_afull or p_aempty values are a configuration error. The block does not check them.

## Timing
- Reset values: rdata=0, full=0, empty=1, afull=0, aempty=1, level=0, ovf=0, udf=0.
- Write-to-flag latency: a write accepted at edge N updates level, empty, afull and full after edge N.
- p_fwft=0, read latency: rd sampled at edge N presents data after edge N. The data is first usable in cycle N+1.
- p_fwft=1, read latency: a word written at edge N is on rdata in cycle N+1, with empty=0 in the same cycle.
- Combinational paths:
  - No path from wr or rd to any output except rdata when p_fwft=1.
  - The rdata path when p_fwft=1 runs from rptr, not from rd.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- Reset, then write 16 words 0x0001..0x0010 with p_nbit_a=4 -> level steps 1..16; afull rises when level reaches 12; aempty falls when level reaches 4; full rises after the 16th write; ovf=0.
- Full FIFO, wr=1 with wdata=0xDEAD, and wr=1 & rd=1 together -> level stays 16 on write-only, drops to 15 on the combined cycle; ovf=1 and stays 1; 0xDEAD is never read back.
- Drain a full FIFO with p_fwft=0, rd held high for 17 cycles -> rdata = 0x0001..0x0010 on the cycles after each pop; the 17th request is rejected; udf=1; empty=1; level=0.
- p_fwft=1, empty FIFO, write 0x00AA -> rdata=0x00AA and empty=0 in the next cycle without rd; one rd pop gives empty=1.
- Continuous wr & rd for 40 cycles at level 5 -> level constant 5; pointers wrap at least twice; data order preserved.
- Assert clr while level=9, and separately drop rst_n mid-stream -> all outputs return to reset values. Subsequent writes and reads start at address 0, and the first word read back is the first word written after clr or reset.
